// File: rtl/bitserial_deserialize.sv
// Bit-serial to parallel deserializer, LSB-first, sync-framed.
// One-entry output register with valid/ready, sticky overrun, frame_err pulse.
module bitserial_deserialize #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_in,
  input  logic             sync,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             done;

  // next state: sync always restarts, otherwise shift until last bit
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    done    = 1'b0;
    if (sync) begin
      state_d    = SHIFT;
      cnt_d      = CW'(1);
      shreg_d    = '0;
      shreg_d[0] = s_in;
    end else if (state == SHIFT) begin
      shreg_d[cnt] = s_in;
      if (cnt == LAST) begin
        done    = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  // framing state and shift register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
    end
  end

  // output slot: load on completion if free or draining, else drop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= sync && (state == SHIFT);
      if (done) begin
        if (!out_valid || out_ready) begin
          out_word  <= shreg_d;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitserial_deserialize.sv
// Self-checking bench for bitserial_deserialize (WIDTH=8).
// Directed scenarios plus random traffic against a bit-list model.
module tb_bitserial_deserialize;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_in;
  logic         sync;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         overrun;
  logic         frame_err;

  int n_checks = 0;
  int n_pass = 0;

  // model state
  int           m_n;
  bit           m_active;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_over;
  bit           m_ferr;
  bit           fe_seen;

  always #5 clk = ~clk;

  bitserial_deserialize #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_in(s_in),
    .sync(sync),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_valid(out_valid),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  // one clock: drive inputs, advance model, settle
  task automatic step(input bit rst, input bit s, input bit sy, input bit rdy);
    bit fe;
    bit dn;
    reset_n   = ~rst;
    s_in      = s;
    sync      = sy;
    out_ready = rdy;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_active = 0; m_acc = '0; m_word = '0;
      m_valid = 0; m_over = 0; m_ferr = 0;
    end else begin
      fe = 0;
      dn = 0;
      if (sy) begin
        fe = m_active;
        m_acc = W'(s);
        m_n = 1;
        m_active = 1;
      end else if (m_active) begin
        m_acc = m_acc | (W'(s) << m_n);
        m_n++;
        if (m_n == W) begin
          dn = 1; m_active = 0; m_n = 0;
        end
      end
      if (dn) begin
        if (!m_valid || rdy) begin
          m_word = m_acc; m_valid = 1;
        end else begin
          m_over = 1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      m_ferr = fe;
    end
    #1;
    if (frame_err === 1'b1) fe_seen = 1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last);
    for (int i = 0; i < W; i++)
      step(0, w[i], i == 0, (i == W - 1) ? rdy_last : rdy);
  endtask

  task automatic do_reset();
    step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    fe_seen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_word, out_valid, overrun, frame_err} !== {8'h00, 3'b000})
      $display("FAIL reset: got word=%h v=%b ov=%b fe=%b want 00/0/0/0",
               out_word, out_valid, overrun, frame_err);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    send_word(8'hA5, 1, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hA5)
      $display("FAIL single_out: got v=%b word=%h want 1/a5", out_valid, out_word);
    else n_pass++;
    step(0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL single_pulse: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'h3C, 0, 0);
    n_checks++;
    if (overrun !== 1'b0)
      $display("FAIL ovr_early: got %b want 0", overrun);
    else n_pass++;
    send_word(8'hC3, 0, 0);
    n_checks++;
    if (out_word !== 8'h3C || out_valid !== 1'b1 || overrun !== 1'b1)
      $display("FAIL ovr_hold: got word=%h v=%b ov=%b want 3c/1/1",
               out_word, out_valid, overrun);
    else n_pass++;
    step(0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || out_word !== 8'h3C)
      $display("FAIL ovr_drain: got v=%b ov=%b word=%h want 0/1/3c",
               out_valid, overrun, out_word);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [W-1:0] w;
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    w = 8'h81;
    for (int i = 0; i < W; i++) begin
      step(0, w[i], i == 0, 0);
      if (i == 0) begin
        n_checks++;
        if (frame_err !== 1'b1)
          $display("FAIL ferr_pulse: got %b want 1", frame_err);
        else n_pass++;
      end
      if (i == 1) begin
        n_checks++;
        if (frame_err !== 1'b0)
          $display("FAIL ferr_once: got %b want 0", frame_err);
        else n_pass++;
      end
    end
    n_checks++;
    if (out_word !== 8'h81 || out_valid !== 1'b1)
      $display("FAIL ferr_word: got word=%h v=%b want 81/1", out_word, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL rstmid_nout: got v=%b want 0", out_valid);
    else n_pass++;
    send_word(8'h5A, 0, 0);
    n_checks++;
    if (out_word !== 8'h5A || out_valid !== 1'b1 || fe_seen)
      $display("FAIL rstmid_word: got word=%h v=%b fe_seen=%b want 5a/1/0",
               out_word, out_valid, fe_seen);
    else n_pass++;
  endtask

  task automatic test_replace();
    do_reset();
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 1);
    n_checks++;
    if (out_word !== 8'h22 || out_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL replace: got word=%h v=%b ov=%b want 22/1/0",
               out_word, out_valid, overrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      w = W'($urandom);
      send_word(w, 1, 1);
      n_checks++;
      if (out_word !== w || out_valid !== 1'b1 || overrun !== 1'b0 || fe_seen)
        $display("FAIL b2b[%0d]: got word=%h v=%b ov=%b fe_seen=%b want %h/1/0/0",
                 k, out_word, out_valid, overrun, fe_seen, w);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit sy;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sy = (m_active ? $urandom_range(0, 11) : $urandom_range(0, 2)) == 0;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1), sy,
           $urandom_range(0, 2) != 0);
      n_checks++;
      if ({out_word, out_valid, overrun, frame_err} !==
          {m_word, m_valid, m_over, m_ferr})
        $display("FAIL random[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 out_word, out_valid, overrun, frame_err,
                 m_word, m_valid, m_over, m_ferr);
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 0; s_in = 0; sync = 0; out_ready = 0;
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_replace();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
